// File: rtl/bp_fe_ras.sv
// Return address stack for the front end: pushes return targets on calls and
// predicts the return target of a ret one cycle later.
`ifndef BP_FE_INSTR_SCAN_CLASS_WIDTH
`define BP_FE_INSTR_SCAN_CLASS_WIDTH 3
`endif

module bp_fe_ras #(
    parameter int eaddr_width_p = 39,
    parameter int ras_entries_p = 4
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic                                      v_i,
    input  logic [`BP_FE_INSTR_SCAN_CLASS_WIDTH-1:0]  scan_class_i,
    input  logic                                      is_compressed_i,
    input  logic [eaddr_width_p-1:0]                  pc_i,
    input  logic                                      flush_i,
    output logic                                      pred_v_o,
    output logic [eaddr_width_p-1:0]                  pred_addr_o,
    output logic                                      empty_o,
    output logic                                      full_o
);

    localparam int ptr_w = $clog2(ras_entries_p);
    localparam int cnt_w = $clog2(ras_entries_p + 1);
    localparam logic [`BP_FE_INSTR_SCAN_CLASS_WIDTH-1:0] e_rvi_call = 3'd4;
    localparam logic [`BP_FE_INSTR_SCAN_CLASS_WIDTH-1:0] e_rvi_ret  = 3'd5;

    logic [eaddr_width_p-1:0] mem_q [ras_entries_p];
    logic [ptr_w-1:0]         top_q, top_d;
    logic [cnt_w-1:0]         count_q, count_d;
    logic                     pred_v_q, pred_v_d;
    logic [eaddr_width_p-1:0] pred_addr_q, pred_addr_d;

    logic                     accept, push, pop, is_full;
    logic [eaddr_width_p-1:0] ret_addr;
    logic [ptr_w-1:0]         push_idx;

    always_comb begin
        is_full     = (count_q == cnt_w'(ras_entries_p));
        accept      = v_i & ~flush_i;
        push        = accept & (scan_class_i == e_rvi_call);
        pop         = accept & (scan_class_i == e_rvi_ret) & (count_q != '0);
        ret_addr    = pc_i + (is_compressed_i ? eaddr_width_p'(2) : eaddr_width_p'(4));
        push_idx    = top_q + ptr_w'(1);

        top_d       = top_q;
        count_d     = count_q;
        pred_v_d    = 1'b0;
        pred_addr_d = pred_addr_q;

        if (flush_i) begin
            top_d   = '0;
            count_d = '0;
        end else if (push) begin
            // A push while full reuses the oldest slot, so the count just saturates.
            top_d   = push_idx;
            count_d = is_full ? count_q : count_q + cnt_w'(1);
        end else if (pop) begin
            pred_v_d    = 1'b1;
            pred_addr_d = mem_q[top_q];
            top_d       = top_q - ptr_w'(1);
            count_d     = count_q - cnt_w'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            top_q       <= '0;
            count_q     <= '0;
            pred_v_q    <= 1'b0;
            pred_addr_q <= '0;
        end else begin
            top_q       <= top_d;
            count_q     <= count_d;
            pred_v_q    <= pred_v_d;
            pred_addr_q <= pred_addr_d;
        end
    end

    // Entry storage is deliberately left out of reset and flush.
    always_ff @(posedge clk_i) begin
        if (push && !reset_i) begin
            mem_q[push_idx] <= ret_addr;
        end
    end

    assign pred_v_o    = pred_v_q;
    assign pred_addr_o = pred_addr_q;
    assign empty_o     = (count_q == '0);
    assign full_o      = is_full;

endmodule

// File: tb/tb_bp_fe_ras.sv
// Bench for bp_fe_ras: directed vector table followed by random traffic
// compared against a queue-based stack model.
module tb_bp_fe_ras;

    localparam int aw = 39;
    localparam int depth = 4;
    localparam logic [2:0] c_call  = 3'd4;
    localparam logic [2:0] c_ret   = 3'd5;
    localparam logic [2:0] c_jal   = 3'd2;
    localparam logic [2:0] c_other = 3'd0;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          v_i = 1'b0;
    logic [2:0]    scan_class_i = c_other;
    logic          is_compressed_i = 1'b0;
    logic [aw-1:0] pc_i = '0;
    logic          flush_i = 1'b0;
    logic          pred_v_o;
    logic [aw-1:0] pred_addr_o;
    logic          empty_o;
    logic          full_o;

    int checks = 0;
    int errors = 0;

    logic [aw-1:0] model_q[$];
    logic          m_pv = 1'b0;
    logic [aw-1:0] m_pa = '0;

    typedef struct {
        logic          rst;
        logic          fl;
        logic          v;
        logic [2:0]    cls;
        logic          comp;
        logic [aw-1:0] pc;
        logic          e_pv;
        logic [aw-1:0] e_pa;
        logic          e_empty;
        logic          e_full;
    } vec_t;
    vec_t vecs[$];

    bp_fe_ras #(.eaddr_width_p(aw), .ras_entries_p(depth)) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .scan_class_i(scan_class_i),
        .is_compressed_i(is_compressed_i), .pc_i(pc_i), .flush_i(flush_i),
        .pred_v_o(pred_v_o), .pred_addr_o(pred_addr_o), .empty_o(empty_o), .full_o(full_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic fl, logic v, logic [2:0] cls, logic comp,
                                logic [aw-1:0] pc, logic e_pv, logic [aw-1:0] e_pa,
                                logic e_empty, logic e_full);
        vec_t r;
        r.rst = rst; r.fl = fl; r.v = v; r.cls = cls; r.comp = comp; r.pc = pc;
        r.e_pv = e_pv; r.e_pa = e_pa; r.e_empty = e_empty; r.e_full = e_full;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stack model: newest entry at the back, oldest dropped on overflow.
    task automatic model_step(input logic rst, input logic fl, input logic v,
                              input logic [2:0] cls, input logic comp, input logic [aw-1:0] pc);
        logic [aw-1:0] ret;
        ret = pc + (comp ? 2 : 4);
        m_pv = 1'b0;
        if (rst) begin
            model_q.delete();
            m_pa = '0;
        end else if (fl) begin
            model_q.delete();
        end else if (v && cls == c_call) begin
            if (model_q.size() == depth) void'(model_q.pop_front());
            model_q.push_back(ret);
        end else if (v && cls == c_ret && model_q.size() > 0) begin
            m_pa = model_q.pop_back();
            m_pv = 1'b1;
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic v,
                         input logic [2:0] cls, input logic comp, input logic [aw-1:0] pc);
        reset_i = rst; flush_i = fl; v_i = v; scan_class_i = cls;
        is_compressed_i = comp; pc_i = pc;
        @(posedge clk);
        #1;
        model_step(rst, fl, v, cls, comp, pc);
    endtask

    initial begin
        // reset
        vecs.push_back(mk(1,0,1,c_ret, 0,39'h0,         0,39'h0,1,0));
        // call 0x1000 then ret
        vecs.push_back(mk(0,0,1,c_call,0,39'h1000,      0,39'h0,0,0));
        vecs.push_back(mk(0,0,1,c_ret, 0,39'h0,         1,39'h1004,1,0));
        vecs.push_back(mk(0,0,0,c_other,0,39'h0,        0,39'h1004,1,0));
        // compressed calls, including address wrap
        vecs.push_back(mk(0,0,1,c_call,1,39'h2002,      0,39'h1004,0,0));
        vecs.push_back(mk(0,0,1,c_ret, 0,39'h0,         1,39'h2004,1,0));
        vecs.push_back(mk(0,0,1,c_call,1,39'h7FFFFFFFFE,0,39'h2004,0,0));
        vecs.push_back(mk(0,0,1,c_ret, 0,39'h0,         1,39'h0,1,0));
        // overflow by one then drain
        vecs.push_back(mk(0,0,1,c_call,0,39'h100,       0,39'h0,0,0));
        vecs.push_back(mk(0,0,1,c_call,0,39'h200,       0,39'h0,0,0));
        vecs.push_back(mk(0,0,1,c_call,0,39'h300,       0,39'h0,0,0));
        vecs.push_back(mk(0,0,1,c_call,0,39'h400,       0,39'h0,0,1));
        vecs.push_back(mk(0,0,1,c_call,0,39'h500,       0,39'h0,0,1));
        vecs.push_back(mk(0,0,1,c_ret, 0,39'h0,         1,39'h504,0,0));
        vecs.push_back(mk(0,0,1,c_ret, 0,39'h0,         1,39'h404,0,0));
        vecs.push_back(mk(0,0,1,c_ret, 0,39'h0,         1,39'h304,0,0));
        vecs.push_back(mk(0,0,1,c_ret, 0,39'h0,         1,39'h204,1,0));
        vecs.push_back(mk(0,0,1,c_ret, 0,39'h0,         0,39'h204,1,0));
        // ret while empty, then call/ret
        vecs.push_back(mk(0,0,1,c_ret, 0,39'h0,         0,39'h204,1,0));
        vecs.push_back(mk(0,0,1,c_call,0,39'h40,        0,39'h204,0,0));
        vecs.push_back(mk(0,0,1,c_ret, 0,39'h0,         1,39'h44,1,0));
        // flush concurrent with ret
        vecs.push_back(mk(0,0,1,c_call,0,39'h10,        0,39'h44,0,0));
        vecs.push_back(mk(0,0,1,c_call,0,39'h20,        0,39'h44,0,0));
        vecs.push_back(mk(0,1,1,c_ret, 0,39'h0,         0,39'h44,1,0));
        vecs.push_back(mk(0,0,1,c_ret, 0,39'h0,         0,39'h44,1,0));
        // flush concurrent with call drops the push
        vecs.push_back(mk(0,1,1,c_call,0,39'h60,        0,39'h44,1,0));
        // reset concurrent with ret
        vecs.push_back(mk(0,0,1,c_call,0,39'h30,        0,39'h44,0,0));
        vecs.push_back(mk(0,0,1,c_call,0,39'h50,        0,39'h44,0,0));
        vecs.push_back(mk(0,0,1,c_call,0,39'h70,        0,39'h44,0,0));
        vecs.push_back(mk(1,0,1,c_ret, 0,39'h0,         0,39'h0,1,0));
        vecs.push_back(mk(0,0,1,c_ret, 0,39'h0,         0,39'h0,1,0));
        // other class and v_i=0 leave the stack alone
        vecs.push_back(mk(0,0,1,c_call,0,39'h80,        0,39'h0,0,0));
        vecs.push_back(mk(0,0,1,c_jal, 0,39'h0,         0,39'h0,0,0));
        vecs.push_back(mk(0,0,0,c_ret, 0,39'h0,         0,39'h0,0,0));
        vecs.push_back(mk(0,0,1,c_ret, 0,39'h0,         1,39'h84,1,0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].v, vecs[i].cls, vecs[i].comp, vecs[i].pc);
            check($sformatf("vec%0d pred_v", i),    64'(pred_v_o),    64'(vecs[i].e_pv));
            check($sformatf("vec%0d pred_addr", i), 64'(pred_addr_o), 64'(vecs[i].e_pa));
            check($sformatf("vec%0d empty", i),     64'(empty_o),     64'(vecs[i].e_empty));
            check($sformatf("vec%0d full", i),      64'(full_o),      64'(vecs[i].e_full));
        end

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic          rst, fl, v, comp;
            logic [2:0]    cls;
            logic [aw-1:0] pc;
            int            k;
            rst  = ($urandom_range(0, 63) == 0);
            fl   = ($urandom_range(0, 19) == 0);
            v    = ($urandom_range(0, 3) != 0);
            comp = $urandom_range(0, 1);
            k    = $urandom_range(0, 9);
            cls  = (k < 4) ? c_call : (k < 8) ? c_ret : 3'($urandom_range(0, 3));
            pc   = {7'($urandom), $urandom};
            if ($urandom_range(0, 15) == 0) pc = '1 - aw'($urandom_range(0, 3));
            drive(rst, fl, v, cls, comp, pc);
            check("rnd pred_v",    64'(pred_v_o),    64'(m_pv));
            check("rnd pred_addr", 64'(pred_addr_o), 64'(m_pa));
            check("rnd empty",     64'(empty_o),     64'(model_q.size() == 0));
            check("rnd full",      64'(full_o),      64'(model_q.size() == depth));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_fe_ras.md
BP_FE_RAS -- requirements
Module: bp_fe_ras

Interface
REQ-001 The block SHALL have parameter eaddr_width_p, default "inv", meaning the effective address width in bits.
REQ-002 The block SHALL have parameter ras_entries_p, default "inv", meaning the stack depth; it SHALL be a power of 2 and at least 2.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: clk_i  input  1  clock, rising edge only.
REQ-004 reset_i  input  1  synchronous active-high reset.
REQ-005 v_i  input  1  scanned instruction valid this cycle.
REQ-006 scan_class_i  input  `bp_fe_instr_scan_class_width  instruction scan class (e_rvi_call, e_rvi_ret, others).
REQ-007 is_compressed_i  input  1  scanned instruction is 16-bit.
REQ-008 pc_i  input  eaddr_width_p  PC of the scanned instruction.
REQ-009 flush_i  input  1  discard all stack contents.
REQ-010 pred_v_o  output  1  return-target prediction valid; a one-cycle pulse.
REQ-011 pred_addr_o  output  eaddr_width_p  predicted return target.
REQ-012 empty_o  output  1  stack holds 0 entries.
REQ-013 full_o  output  1  stack holds ras_entries_p entries.

Function
REQ-014 Storage SHALL be a circular array of ras_entries_p entries, each eaddr_width_p wide, with top pointer top_r (log2(ras_entries_p) bits) and occupancy count_r (0..ras_entries_p).
REQ-015 An access SHALL be accepted when v_i=1 and flush_i=0; no backpressure is applied.
REQ-016 Push: on an accepted e_rvi_call, the block SHALL compute ret = pc_i + (is_compressed_i ? 2 : 4), modulo 2^eaddr_width_p.
REQ-017 On a push, the block SHALL write ret to entry (top_r+1) mod ras_entries_p and set top_r to that index.
REQ-018 On a push, count_r SHALL increment and saturate at ras_entries_p.
REQ-019 A push when full SHALL silently overwrite the oldest entry.
REQ-020 Pop: on an accepted e_rvi_ret with count_r>0, the block SHALL set pred_v_o=1 and pred_addr_o=entry[top_r] in the next cycle (1-cycle registered latency).
REQ-021 On a non-empty pop, top_r SHALL become (top_r-1) mod ras_entries_p and count_r SHALL decrement.
REQ-022 On an accepted e_rvi_ret with count_r=0, the block SHALL drive pred_v_o=0 next cycle and leave top_r, count_r and pred_addr_o unchanged.
REQ-023 Accepted instructions of any other class, and cycles with v_i=0, SHALL change no state and drive pred_v_o=0 next cycle.
REQ-024 pred_addr_o SHALL hold its last value whenever pred_v_o=0.
REQ-025 Flush: flush_i=1 SHALL set top_r=0 and count_r=0 and drive pred_v_o=0 next cycle.
REQ-026 flush_i SHALL override any v_i in the same cycle; that access is dropped.
REQ-027 Entry contents SHALL NOT be cleared by flush.
REQ-028 empty_o SHALL equal (count_r==0) and full_o SHALL equal (count_r==ras_entries_p), both derived combinationally from registered state.
REQ-029 Push order then pop order SHALL be strictly LIFO for up to ras_entries_p outstanding entries.
REQ-030 After overflow, a pop sequence SHALL return the newest ras_entries_p addresses in LIFO order, then report empty.

Reset
REQ-031 While reset_i=1 at a rising edge, the block SHALL set top_r=0, count_r=0, pred_v_o=0 and pred_addr_o=0; empty_o SHALL then read 1 and full_o 0.
REQ-032 Reset SHALL take priority over flush_i and v_i, discarding any access in flight, including a pending pred_v_o pulse.
REQ-033 Stack entry storage SHALL NOT require reset.

Verification (eaddr_width_p=39, ras_entries_p=4)
REQ-034 Call at pc 0x1000, is_compressed_i=0, then ret -> the cycle after the ret, pred_v_o=1 and pred_addr_o=0x1004, then empty_o=1.
REQ-035 Compressed call at pc 0x2002, then ret -> pred_addr_o=0x2004; a call at pc 0x7FFFFFFFFE (compressed) pushes 0x0000000000 (wrap).
REQ-036 Calls at 0x100, 0x200, 0x300, 0x400, 0x500 (uncompressed) -> full_o=1 after the 4th call; five rets yield 0x504, 0x404, 0x304, 0x204, then pred_v_o=0 with empty_o=1.
REQ-037 Ret while empty -> pred_v_o=0 and pred_addr_o unchanged; a following call at 0x40 then ret -> 0x44.
REQ-038 Two calls, then flush_i=1 in the same cycle as a ret -> no pred_v_o pulse and empty_o=1; a subsequent ret -> pred_v_o=0.
REQ-039 Three calls, then reset_i=1 for one cycle concurrent with a ret -> pred_v_o=0, pred_addr_o=0, empty_o=1, full_o=0.
